dm_resp: RTL

Multi-cycle data-memory responder answering the CPU's load/store requests over a req/ready handshake. Holds 1 KiB of word-organised storage, inserts a configurable number of wait states, and performs byte loads and stores internally: sign-extended byte reads and read-modify-write byte writes. Sits between the multi-cycle controller's memory stage and the data array, replacing the direct combinational dm_1k path.

---
 rtl/dm_resp.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/dm_resp.sv
// dm_resp: multi-cycle data-memory responder with configurable wait states over a req/ready handshake.
// Define DM_RESP_BYTE_EN to enable sign-extended byte loads and read-modify-write byte stores.
module dm_resp #(
   parameter int WAIT_CYCLES = 1,
   parameter int DEPTH_WORDS = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        we,
   input  logic        byte_op,   // the byte strobe; "byte" is a reserved word
   input  logic [9:0]  addr,
   input  logic [31:0] wdata,
   output logic        ready,
   output logic [31:0] rdata,
   output logic        busy,
   output logic        err
);
   localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   logic [3:0]       cnt_reg;
   logic [7:0]       word_reg;
   logic [31:0]      wdata_reg, rdata_reg, mem_word, mem_wdata;
   logic             we_reg, err_reg, acc_byte, req_byte, misaligned, mem_we;
   logic [IDX_W-1:0] idx;
   logic [31:0]      mem [DEPTH_WORDS];

   function automatic logic [IDX_W-1:0] wrap_idx(input logic [7:0] w);
      return IDX_W'(int'(w) % DEPTH_WORDS);
   endfunction

`ifdef DM_RESP_BYTE_EN
   typedef enum logic [2:0] {IDLE, WAIT, ACC, RMW, DONE} state_t;
   logic        byte_reg;
   logic [1:0]  lane_reg;
   logic [31:0] hold_reg, merged, lane_sext;
   assign req_byte = byte_op;
   assign acc_byte = byte_reg;
   always_comb begin
      merged = hold_reg;
      merged[{lane_reg, 3'b000} +: 8] = wdata_reg[7:0];
      lane_sext = {{24{mem_word[{lane_reg, 3'b111}]}}, mem_word[{lane_reg, 3'b000} +: 8]};
   end
`else
   typedef enum logic [2:0] {IDLE, WAIT, ACC, DONE} state_t;
   logic byte_op_unused;
   assign byte_op_unused = byte_op;
   assign req_byte = 1'b0;
   assign acc_byte = 1'b0;
`endif

   state_t state_reg, state_next;

   // Byte accesses can never be misaligned; word accesses need addr[1:0] == 0.
   assign misaligned = !req_byte && (addr[1:0] != 2'b00);
   assign idx        = wrap_idx(word_reg);
   assign mem_word   = mem[idx];

   assign ready = (state_reg == DONE);
   assign busy  = (state_reg != IDLE);
   assign rdata = rdata_reg;
   assign err   = err_reg;

   always_ff @(posedge clk) begin
      if (rst) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (req) begin
               if (misaligned)            state_next = DONE;
               else if (WAIT_CYCLES == 0) state_next = ACC;
               else                       state_next = WAIT;
            end
         end
         WAIT: if (cnt_reg == 4'd0) state_next = ACC;
         ACC: begin
            state_next = DONE;
`ifdef DM_RESP_BYTE_EN
            if (byte_reg && we_reg) state_next = RMW;
`endif
         end
`ifdef DM_RESP_BYTE_EN
         RMW:  state_next = DONE;
`endif
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_reg   <= 4'd0;
         we_reg    <= 1'b0;
         word_reg  <= 8'd0;
         wdata_reg <= 32'd0;
         rdata_reg <= 32'd0;
         err_reg   <= 1'b0;
`ifdef DM_RESP_BYTE_EN
         byte_reg  <= 1'b0;
         lane_reg  <= 2'd0;
         hold_reg  <= 32'd0;
`endif
      end else begin
         case (state_reg)
            IDLE: begin
               if (req) begin
                  we_reg    <= we;
                  word_reg  <= addr[9:2];
                  wdata_reg <= wdata;
                  cnt_reg   <= (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
`ifdef DM_RESP_BYTE_EN
                  byte_reg  <= byte_op;
                  lane_reg  <= addr[1:0];
`endif
                  if (misaligned) begin
                     rdata_reg <= 32'd0;
                     err_reg   <= 1'b1;
                  end
               end
            end
            WAIT: if (cnt_reg != 4'd0) cnt_reg <= cnt_reg - 4'd1;
            ACC: begin
`ifdef DM_RESP_BYTE_EN
               if (!we_reg)       rdata_reg <= byte_reg ? lane_sext : mem_word;
               else if (byte_reg) hold_reg  <= mem_word;
`else
               if (!we_reg) rdata_reg <= mem_word;
`endif
            end
            DONE:    err_reg <= 1'b0;
            default: ;
         endcase
      end
   end

   // Single write port; reset on the same edge suppresses the write.
   always_comb begin
      mem_we    = !rst && (state_reg == ACC) && we_reg && !acc_byte;
      mem_wdata = wdata_reg;
`ifdef DM_RESP_BYTE_EN
      if (state_reg == RMW) begin
         mem_we    = !rst;
         mem_wdata = merged;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (mem_we) mem[idx] <= mem_wdata;
   end
endmodule
